// File: rtl/alu_pkg.sv
// Shared types and helpers for the execute stage: ALU opcodes, FSM states and
// default widths.
package alu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_MUL = 4'b0110,
        ALU_XOR = 4'b0111
    } alu_op_e;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_e;

    // Any code with the top bit set is outside the decoder's op space.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu_execute_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle over XLEN cycles,
// keeping the low XLEN bits of the product.
module seq_mul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic [XLEN-1:0]  mcand_reg;
    logic [XLEN-1:0]  mplier_reg;
    logic [XLEN-1:0]  acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic [XLEN-1:0]  acc_next;

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    // done marks the cycle whose edge retires the last step; product already
    // includes that step's addition so the caller can capture it on the same edge.
    assign done    = (count_reg == CNT_W'(1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
        end else if (start) begin
            mcand_reg  <= multiplicand;
            mplier_reg <= multiplier;
            acc_reg    <= '0;
            count_reg  <= CNT_W'(XLEN);
        end else if (count_reg != '0) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_execute.sv
// Execute stage: single-cycle ALU ops plus an iterative MUL, with a valid/ready
// handshake on input and a one-deep registered result slot on output.
module alu_execute
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RD_W    = 5,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic            regwrite_control,
    input  logic [RD_W-1:0] rd_addr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            wb_regwrite,
    output logic [RD_W-1:0] wb_rd,
    output logic            busy,
    output logic            err_illegal
);

    state_e state_reg, state_next;

    logic            out_valid_reg;
    logic [XLEN-1:0] result_reg;
    logic            wb_regwrite_reg;
    logic [RD_W-1:0] wb_rd_reg;
    logic            err_illegal_reg;
    logic [RD_W-1:0] mul_rd_reg;
    logic            mul_regwrite_reg;

    logic            accept;
    logic            op_is_mul;
    logic            op_is_illegal;
    logic            mul_start;
    logic            mul_done_raw;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic [XLEN-1:0] single_result;
    logic [XLEN-1:0] and_bits, or_bits, xor_bits;
    logic [SHAMT_W-1:0] shamt;

    // A new op may enter only when idle and the output slot is empty or draining.
    assign in_ready      = !rst && (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept        = in_valid && in_ready;
    assign op_is_mul     = (alu_control == ALU_MUL);
    assign op_is_illegal = is_illegal(alu_control);
    assign mul_start     = accept && op_is_mul;
    assign mul_done      = (state_reg == MUL_RUN) && mul_done_raw;
    assign shamt         = op_b[SHAMT_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_bitwise
            assign and_bits[gi] = op_a[gi] & op_b[gi];
            assign or_bits[gi]  = op_a[gi] | op_b[gi];
            assign xor_bits[gi] = op_a[gi] ^ op_b[gi];
        end
    endgenerate

    always_comb begin
        single_result = '0;
        case (alu_control)
            ALU_AND: single_result = and_bits;
            ALU_OR:  single_result = or_bits;
            ALU_XOR: single_result = xor_bits;
            ALU_ADD: single_result = op_a + op_b;
            ALU_SUB: single_result = op_a + ~op_b + XLEN'(1);
            ALU_SLL: single_result = op_a << shamt;
            ALU_SRL: single_result = op_a >> shamt;
            default: single_result = '0;
        endcase
    end

    seq_mul #(
        .XLEN(XLEN)
    ) u_seq_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (mul_start),
        .multiplicand (op_a),
        .multiplier   (op_b),
        .done         (mul_done_raw),
        .product      (mul_product)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mul_start) state_next = MUL_RUN;
            MUL_RUN: if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            result_reg       <= '0;
            wb_regwrite_reg  <= 1'b0;
            wb_rd_reg        <= '0;
            err_illegal_reg  <= 1'b0;
            mul_rd_reg       <= '0;
            mul_regwrite_reg <= 1'b0;
        end else begin
            err_illegal_reg <= 1'b0;
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                if (op_is_mul) begin
                    mul_rd_reg       <= rd_addr;
                    mul_regwrite_reg <= regwrite_control;
                end else begin
                    result_reg      <= single_result;
                    wb_regwrite_reg <= regwrite_control && !op_is_illegal;
                    wb_rd_reg       <= rd_addr;
                    out_valid_reg   <= 1'b1;
                    err_illegal_reg <= op_is_illegal;
                end
            end
            // The slot is guaranteed free here: MUL was only accepted into an
            // empty or draining slot and nothing else enters while it runs.
            if (mul_done) begin
                result_reg      <= mul_product;
                wb_regwrite_reg <= mul_regwrite_reg;
                wb_rd_reg       <= mul_rd_reg;
                out_valid_reg   <= 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign result      = result_reg;
    assign wb_regwrite = wb_regwrite_reg;
    assign wb_rd       = wb_rd_reg;
    assign err_illegal = err_illegal_reg;
    assign busy        = (state_reg == MUL_RUN);

endmodule

// File: doc/alu_execute.md
Name: alu_execute

Overview:
Execute stage directly downstream of the instruction decoder. Consumes the decoder's 4-bit ALU operation code and register-write flag together with two XLEN-bit operands and the destination register index. Produces a registered result for writeback. Single-cycle ops take 1 cycle; MUL runs as an iterative shift-add over XLEN cycles behind a valid/ready handshake on both sides.

Parameters:
XLEN, 32, operand/result width
RD_W, 5, destination register index width
SHAMT_W, 5, shift-amount width (log2 XLEN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream presents an operation
in_ready  out  1  stage can accept; transfer when in_valid && in_ready
alu_control  in  4  op: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0110 MUL, 0111 XOR; 1xxx illegal
regwrite_control  in  1  writeback enable from decoder
rd_addr  in  RD_W  destination register
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B
out_valid  out  1  result register holds an undrained result
out_ready  in  1  downstream accepts; drain when out_valid && out_ready
result  out  XLEN  registered result
wb_regwrite  out  1  registered writeback enable
wb_rd  out  RD_W  registered destination
busy  out  1  MUL iteration in progress
err_illegal  out  1  one-cycle pulse, aligned with out_valid rising, for an illegal op

Behaviour:
- Reset (rst high at an edge): state IDLE; out_valid, result, wb_regwrite, wb_rd, busy, err_illegal all 0; MUL counter cleared. in_ready is forced 0 while rst is high.
- FSM states: IDLE, MUL_RUN.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full throughput.
- IDLE, accept non-MUL: at the accept edge, result, wb_regwrite, wb_rd and out_valid=1 load together. Latency is 1 cycle.
- IDLE, accept MUL: at the accept edge, load multiplicand=op_a, multiplier=op_b, acc=0, count=XLEN. Also latch rd_addr and regwrite_control, set busy=1, and move to MUL_RUN.
  - If out_valid was 1 and out_ready was 1 on that edge, out_valid clears.
- MUL_RUN, each edge:
  - If multiplier[0], acc += multiplicand (mod 2^XLEN).
  - multiplicand <<= 1; multiplier >>= 1; count--.
  - On the edge where count goes 1→0: result=acc (including the final step's addition), out_valid=1, busy=0, state IDLE.
  - MUL latency is XLEN cycles after the accept edge, and the result is the low XLEN bits of the product.
- Arithmetic, all mod 2^XLEN:
  - ADD/SUB wrap with no flags; SUB is op_a + ~op_b + 1.
  - SLL/SRL use op_b[SHAMT_W-1:0] only; SRL is logical and zero-fills.
- Illegal op (alu_control[3]=1): result=0, wb_regwrite forced 0, err_illegal pulses for one cycle. Latency is 1.
- Output hold: while out_valid && !out_ready, result, wb_regwrite and wb_rd stay stable. A MUL in MUL_RUN cannot complete into a full slot; this cannot occur, because MUL is accepted only when the slot is free or draining.
- Simultaneous drain and accept of a single-cycle op: the new result overwrites and out_valid stays 1.
- Reset mid-MUL: the operation is abandoned with no output, and state is IDLE on the following cycle.
- Inputs are sampled only on the accept edge; operand changes during MUL_RUN have no effect.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum holding the 4-bit codes above.
  - state_e {IDLE, MUL_RUN}.
  - Constants XLEN_DEF=32 and SHAMT_W_DEF=5.
  - Helper function is_illegal(op).
- One sub-module, seq_mul: shift-add iterator with start, done, multiplicand/multiplier/acc registers and counter.
- alu_execute owns the FSM, handshake and output register.

Test Plan:
- ADD: op_a=5, op_b=7, alu_control=0010, rd=3, regwrite=1 → next cycle out_valid=1, result=12, wb_rd=3, wb_regwrite=1.
- SUB wrap and SLL mask:
  - 3−5 → 0xFFFFFFFE.
  - SLL 1 by op_b=33 → result=2.
  - SRL 0x80000000 by 31 → 1.
- MUL: 0x0000FFFF × 0x00010001 → out_valid exactly 32 cycles after accept, result=0xFFFFFFFF. in_ready and busy behave as follows throughout:
  - in_ready=0 and busy=1 across MUL_RUN.
  - busy=0 and in_ready=1 once out_valid rises.
- Backpressure: out_ready=0 after an ADD result → result held for 5 cycles, in_ready=0. Then out_ready=1 with a new XOR 0xF0F0^0x0FF0 in the same cycle → next result=0xFF00 with out_valid continuously 1.
- Reset mid-MUL: rst pulse on cycle 10 of MUL_RUN → out_valid=0, busy=0. A following ADD 1+1 returns 2 with latency 1.
- Illegal: alu_control=1010, regwrite=1 → result=0, wb_regwrite=0, err_illegal high for exactly one cycle.
